// File: rtl/addern_pipe.sv
// addern_pipe: pipelined N-bit ripple-carry adder/subtractor, one W-bit chunk per stage.
// Optional signed-overflow output is compiled in when ADDERN_PIPE_OVF_EN is defined.
module addern_pipe #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic         carryin,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         carryout
`ifdef ADDERN_PIPE_OVF_EN
    ,
    output logic         overflow
`endif
);
    localparam int W    = N / STAGES;
    localparam int LAST = STAGES - 1;

    logic         adv;

    // Per-stage next-state (what stage k captures) and registered state.
    logic [N-1:0] x_d  [STAGES];
    logic [N-1:0] y_d  [STAGES];
    logic         v_d  [STAGES];
    logic [N-1:0] s_in [STAGES];
    logic         c_in [STAGES];
    logic [N-1:0] s_d  [STAGES];
    logic         c_d  [STAGES];

    logic [N-1:0] x_q  [STAGES];
    logic [N-1:0] y_q  [STAGES];
    logic         v_q  [STAGES];
    logic [N-1:0] s_q  [STAGES];
    logic         c_q  [STAGES];

    logic [W:0]   chunk;

    assign adv      = !v_q[LAST] | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage_in
        if (k == 0) begin : g_entry
            assign x_d[k]  = X;
            assign y_d[k]  = sub ? ~Y : Y;
            assign v_d[k]  = in_valid;
            assign s_in[k] = '0;
            assign c_in[k] = sub | carryin;
        end else begin : g_link
            assign x_d[k]  = x_q[k-1];
            assign y_d[k]  = y_q[k-1];
            assign v_d[k]  = v_q[k-1];
            assign s_in[k] = s_q[k-1];
            assign c_in[k] = c_q[k-1];
        end
    end

    // Each stage adds only its own chunk; lower result chunks ride along from earlier stages.
    always_comb begin
        chunk = '0;
        for (int k = 0; k < STAGES; k++) begin
            s_d[k] = '0;
            c_d[k] = 1'b0;
        end
        for (int k = 0; k < STAGES; k++) begin
            chunk            = {1'b0, x_d[k][k*W +: W]} + {1'b0, y_d[k][k*W +: W]}
                             + {{W{1'b0}}, c_in[k]};
            s_d[k]           = s_in[k];
            s_d[k][k*W +: W] = chunk[W-1:0];
            c_d[k]           = chunk[W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                x_q[k] <= '0;
                y_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign S         = s_q[LAST];
    assign carryout  = c_q[LAST];

`ifdef ADDERN_PIPE_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // x ^ y ^ sum at the MSB recovers the carry into bit N-1.
    assign ovf_d = x_d[LAST][N-1] ^ y_d[LAST][N-1] ^ s_d[LAST][N-1] ^ c_d[LAST];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_addern_pipe.sv
// Self-checking bench for addern_pipe: scoreboard monitor plus directed and random scenarios.
`timescale 1ns/1ps
module tb_addern_pipe;
    localparam int N      = 32;
    localparam int STAGES = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         sub = 1'b0;
    logic         carryin = 1'b0;
    logic [N-1:0] X = '0;
    logic [N-1:0] Y = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] S;
    logic         carryout;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int out_cnt = 0;
    bit lat_chk = 1'b1;
    bit bp_done = 1'b0;
    bit prev_stall = 1'b0;
    logic [N-1:0] prev_s;
    logic         prev_co;
    logic [N:0]   exp_q[$];
    int           acc_q[$];

`ifdef ADDERN_PIPE_OVF_EN
    logic       ovf32;
    logic       o_in_valid = 1'b0;
    logic       o_in_ready;
    logic       o_sub = 1'b0;
    logic       o_cin = 1'b0;
    logic [7:0] o_X = '0;
    logic [7:0] o_Y = '0;
    logic       o_out_valid;
    logic       o_out_ready = 1'b1;
    logic [7:0] o_S;
    logic       o_co;
    logic       o_ovf;
`endif

    addern_pipe #(.N(N), .STAGES(STAGES)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sub(sub), .carryin(carryin), .X(X), .Y(Y),
        .out_valid(out_valid), .out_ready(out_ready), .S(S), .carryout(carryout)
`ifdef ADDERN_PIPE_OVF_EN
        , .overflow(ovf32)
`endif
    );

`ifdef ADDERN_PIPE_OVF_EN
    addern_pipe #(.N(8), .STAGES(2)) u_ovf (
        .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready),
        .sub(o_sub), .carryin(o_cin), .X(o_X), .Y(o_Y),
        .out_valid(o_out_valid), .out_ready(o_out_ready), .S(o_S), .carryout(o_co),
        .overflow(o_ovf)
    );
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [N:0] model(logic [N-1:0] a, logic [N-1:0] b, logic sb, logic ci);
        logic [N-1:0] bc;
        bc = sb ? ~b : b;
        return {1'b0, a} + {1'b0, bc} + {{N{1'b0}}, (sb ? 1'b1 : ci)};
    endfunction

    // Scoreboard monitor: sampled at negedge, handshakes complete at the following posedge.
    always @(negedge clk) begin
        logic [N:0] e;
        int a;
        if (!rst) begin
            tests++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                failed++;
                $display("FAIL in_ready: got %b want %b", in_ready, !(out_valid && !out_ready));
            end
            if (prev_stall) begin
                tests++;
                if (out_valid !== 1'b1 || S !== prev_s || carryout !== prev_co) begin
                    failed++;
                    $display("FAIL stall_hold: got v=%b S=%h co=%b want v=1 S=%h co=%b",
                             out_valid, S, carryout, prev_s, prev_co);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL spurious_out: got S=%h with no beat expected", S);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    out_cnt++;
                    if ({carryout, S} !== e) begin
                        failed++;
                        $display("FAIL result: got co=%b S=%h want co=%b S=%h",
                                 carryout, S, e[N], e[N-1:0]);
                    end
                    if (lat_chk) begin
                        tests++;
                        if (cyc - a != STAGES) begin
                            failed++;
                            $display("FAIL latency: got %0d want %0d", cyc - a, STAGES);
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(X, Y, sub, carryin));
                acc_q.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_s     = S;
            prev_co    = carryout;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic drive_beat(input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic sb, input logic ci);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; X = a; Y = b; sub = sb; carryin = ci;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++; failed++;
            $display("FAIL accept_timeout: got no in_ready want accept within 1000 cycles");
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n >= 500) begin
            failed++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic directed(input logic [N-1:0] a, input logic [N-1:0] b, input logic sb,
                            input logic ci, input logic [N-1:0] exp_s, input logic exp_co);
        int n;
        out_ready = 1'b1;
        drive_beat(a, b, sb, ci);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n != STAGES || S !== exp_s || carryout !== exp_co) begin
            failed++;
            $display("FAIL directed: got lat=%0d S=%h co=%b want lat=%0d S=%h co=%b",
                     n, S, carryout, STAGES, exp_s, exp_co);
        end
        wait_drain();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || S !== '0 || carryout !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: got v=%b S=%h co=%b want 0 0 0", out_valid, S, carryout);
        end
`ifdef ADDERN_PIPE_OVF_EN
        tests++;
        if (ovf32 !== 1'b0 || o_ovf !== 1'b0) begin
            failed++;
            $display("FAIL reset_ovf: got %b %b want 0 0", ovf32, o_ovf);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_ripple();
        directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        directed(32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0001_0000, 1'b0);
    endtask

    task automatic test_sub();
        directed(32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0);
        directed(32'd7, 32'd5, 1'b1, 1'b0, 32'd2, 1'b1);
        directed(32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1);
        directed(32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    endtask

    task automatic test_back_to_back();
        int start;
        start = out_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++)
            drive_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        wait_drain();
        tests++;
        if (out_cnt - start != 100) begin
            failed++;
            $display("FAIL b2b_count: got %0d want 100", out_cnt - start);
        end
    endtask

    task automatic test_backpressure();
        int start;
        start = out_cnt;
        lat_chk = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    drive_beat($urandom, $urandom, 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)));
                end
                in_valid = 1'b0;
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        lat_chk = 1'b1;
        tests++;
        if (out_cnt - start != 150) begin
            failed++;
            $display("FAIL bp_count: got %0d want 150", out_cnt - start);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            drive_beat($urandom, $urandom, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        #1;
        tests++;
        if (out_valid !== 1'b0 || S !== '0) begin
            failed++;
            $display("FAIL midreset_async: got v=%b S=%h want v=0 S=0", out_valid, S);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b0) begin
                failed++;
                $display("FAIL midreset_emit: got out_valid=%b want 0", out_valid);
            end
        end
        directed(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0);
    endtask

`ifdef ADDERN_PIPE_OVF_EN
    task automatic ovf_beat(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp_s, input logic exp_ovf, input logic exp_co);
        o_out_ready = 1'b1;
        o_in_valid = 1'b1; o_X = a; o_Y = b; o_sub = 1'b0; o_cin = 1'b0;
        @(posedge clk); #1;
        o_in_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (o_out_valid !== 1'b1 || o_S !== exp_s || o_ovf !== exp_ovf || o_co !== exp_co) begin
            failed++;
            $display("FAIL overflow: got v=%b S=%h ovf=%b co=%b want v=1 S=%h ovf=%b co=%b",
                     o_out_valid, o_S, o_ovf, o_co, exp_s, exp_ovf, exp_co);
        end
    endtask

    task automatic test_overflow();
        ovf_beat(8'h7F, 8'h01, 8'h80, 1'b1, 1'b0);
        ovf_beat(8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
        ovf_beat(8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_ripple();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef ADDERN_PIPE_OVF_EN
        test_overflow();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
